// File: rtl/keypad_pkg.sv
// Shared scan-code constants, FSM encoding and BCD helper for the keypad entry controller.
package keypad_pkg;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_TAB   = 8'h0D;

    localparam logic [7:0] SC_D0 = 8'h45;
    localparam logic [7:0] SC_D1 = 8'h16;
    localparam logic [7:0] SC_D2 = 8'h1E;
    localparam logic [7:0] SC_D3 = 8'h26;
    localparam logic [7:0] SC_D4 = 8'h25;
    localparam logic [7:0] SC_D5 = 8'h2E;
    localparam logic [7:0] SC_D6 = 8'h36;
    localparam logic [7:0] SC_D7 = 8'h3D;
    localparam logic [7:0] SC_D8 = 8'h3E;
    localparam logic [7:0] SC_D9 = 8'h46;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIGITS = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Three packed BCD digits {d2,d1,d0} to binary; 999 still fits in 10 bits.
    function automatic logic [9:0] bcd_value(input logic [11:0] d);
        return 10'(d[11:8]) * 10'd100 + 10'(d[7:4]) * 10'd10 + 10'(d[3:0]);
    endfunction

endpackage

// File: rtl/scancode_to_digit.sv
// Maps a set-2 make code to its decimal digit; is_digit is low for any other code.
module scancode_to_digit
    import keypad_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_digit,
    output logic [3:0] digit
);

    always_comb begin
        is_digit = 1'b1;
        digit    = 4'd0;
        case (code)
            SC_D0: digit = 4'd0;
            SC_D1: digit = 4'd1;
            SC_D2: digit = 4'd2;
            SC_D3: digit = 4'd3;
            SC_D4: digit = 4'd4;
            SC_D5: digit = 4'd5;
            SC_D6: digit = 4'd6;
            SC_D7: digit = 4'd7;
            SC_D8: digit = 4'd8;
            SC_D9: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

endmodule

// File: rtl/keypad_entry_controller.sv
// Turns PS/2 make/break/extended bytes into clamped 3-digit parameter commits tagged
// with a Tab-selected effect target; abandons idle entries after a timeout.
module keypad_entry_controller
    import keypad_pkg::*;
#(
    parameter int NUM_TARGETS    = 4,
    parameter int MAX_VALUE      = 100,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [7:0]                     received_data,
    input  logic                           key_pressed,
    output logic [7:0]                     final_data,
    output logic                           final_valid,
    output logic [$clog2(NUM_TARGETS)-1:0] target_sel,
    output logic [1:0]                     digit_count,
    output logic [11:0]                    entry_digits,
    output logic                           entry_error
);

    localparam int TW = $clog2(NUM_TARGETS);

    state_t          state_q, state_d;
    logic            brk_q, brk_d;
    logic            ext_q, ext_d;
    logic [11:0]     digits_q, digits_d;
    logic [1:0]      count_q, count_d;
    logic [9:0]      value_q, value_d;
    logic [27:0]     timer_q, timer_d;
    logic [7:0]      final_data_q, final_data_d;
    logic            final_valid_q, final_valid_d;
    logic            entry_error_q, entry_error_d;
    logic [TW-1:0]   target_q, target_d;

    logic            code_is_digit;
    logic [3:0]      code_digit;
    logic            is_prefix;
    logic            key_valid;
    logic            key_digit, key_enter, key_bksp, key_esc, key_tab;

    scancode_to_digit u_scancode_to_digit (
        .code     (received_data),
        .is_digit (code_is_digit),
        .digit    (code_digit)
    );

    // A keystroke survives only if it is not a prefix, not a break, and (if extended) is keypad Enter.
    always_comb begin
        is_prefix = key_pressed && (received_data == SC_BREAK || received_data == SC_EXT);
        key_valid = key_pressed && !is_prefix && !brk_q && (!ext_q || received_data == SC_ENTER);
        key_digit = key_valid && code_is_digit;
        key_enter = key_valid && (received_data == SC_ENTER);
        key_bksp  = key_valid && (received_data == SC_BKSP);
        key_esc   = key_valid && (received_data == SC_ESC);
        key_tab   = key_valid && (received_data == SC_TAB);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            digits_q      <= '0;
            count_q       <= '0;
            value_q       <= '0;
            timer_q       <= '0;
            final_data_q  <= '0;
            final_valid_q <= 1'b0;
            entry_error_q <= 1'b0;
            target_q      <= '0;
        end else begin
            state_q       <= state_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            digits_q      <= digits_d;
            count_q       <= count_d;
            value_q       <= value_d;
            timer_q       <= timer_d;
            final_data_q  <= final_data_d;
            final_valid_q <= final_valid_d;
            entry_error_q <= entry_error_d;
            target_q      <= target_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        brk_d         = brk_q;
        ext_d         = ext_q;
        digits_d      = digits_q;
        count_d       = count_q;
        value_d       = value_q;
        timer_d       = '0;
        final_data_d  = final_data_q;
        final_valid_d = 1'b0;
        entry_error_d = 1'b0;
        target_d      = target_q;

        if (key_pressed) begin
            if (received_data == SC_BREAK) begin
                brk_d = 1'b1;
            end else if (received_data == SC_EXT) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE, S_COMMIT: begin
                // The commit cycle also serves a new byte as if already idle with an empty entry.
                if (state_q == S_COMMIT) begin
                    final_data_d  = (value_q > 10'(MAX_VALUE)) ? 8'(MAX_VALUE) : value_q[7:0];
                    final_valid_d = 1'b1;
                    digits_d      = '0;
                    count_d       = '0;
                    state_d       = S_IDLE;
                end
                if (key_digit) begin
                    digits_d = {8'h00, code_digit};
                    count_d  = 2'd1;
                    state_d  = S_DIGITS;
                end else if (key_tab) begin
                    target_d = (target_q == TW'(NUM_TARGETS - 1)) ? '0 : target_q + TW'(1);
                end else if (key_enter) begin
                    entry_error_d = 1'b1;
                end
            end

            S_DIGITS: begin
                timer_d = key_pressed ? '0 : timer_q + 28'd1;
                if (key_digit) begin
                    if (count_q == 2'd3) begin
                        entry_error_d = 1'b1;
                    end else begin
                        digits_d = {digits_q[7:0], code_digit};
                        count_d  = count_q + 2'd1;
                    end
                end else if (key_bksp) begin
                    digits_d = {4'h0, digits_q[11:4]};
                    count_d  = count_q - 2'd1;
                    if (count_q == 2'd1) begin
                        state_d = S_IDLE;
                    end
                end else if (key_esc) begin
                    digits_d = '0;
                    count_d  = '0;
                    state_d  = S_IDLE;
                end else if (key_enter) begin
                    value_d = bcd_value(digits_q);
                    state_d = S_COMMIT;
                end else if (!key_pressed && timer_q == 28'(TIMEOUT_CYCLES - 1)) begin
                    digits_d      = '0;
                    count_d       = '0;
                    state_d       = S_IDLE;
                    entry_error_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign final_data   = final_data_q;
    assign final_valid  = final_valid_q;
    assign target_sel   = target_q;
    assign digit_count  = count_q;
    assign entry_digits = digits_q;
    assign entry_error  = entry_error_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed bench for keypad_entry_controller with 3 targets and a 16-cycle timeout.
module tb_keypad_entry_controller;

    logic        clock;
    logic        reset;
    logic [7:0]  receivedData;
    logic        keyPressed;
    logic [7:0]  finalData;
    logic        finalValid;
    logic [1:0]  targetSel;
    logic [1:0]  digitCount;
    logic [11:0] entryDigits;
    logic        entryError;

    int checkCount;
    int failCount;

    keypad_entry_controller #(
        .NUM_TARGETS    (3),
        .MAX_VALUE      (100),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .Clock         (clock),
        .Reset         (reset),
        .received_data (receivedData),
        .key_pressed   (keyPressed),
        .final_data    (finalData),
        .final_valid   (finalValid),
        .target_sel    (targetSel),
        .digit_count   (digitCount),
        .entry_digits  (entryDigits),
        .entry_error   (entryError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one byte for exactly one rising edge; returns at the falling edge after it.
    task automatic applyStimulus(input logic [7:0] code);
        @(negedge clock);
        receivedData = code;
        keyPressed   = 1'b1;
        @(negedge clock);
        keyPressed   = 1'b0;
        receivedData = 8'h00;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic commitAndCheck(input string tag, input bit useExt, input logic [7:0] expVal, input logic [1:0] expTarget);
        if (useExt) applyStimulus(8'hE0);
        applyStimulus(8'h5A);
        checkOutput({tag, "_valid_early"}, finalValid, 1'b0);
        @(negedge clock);
        checkOutput({tag, "_valid"}, finalValid, 1'b1);
        checkOutput({tag, "_data"}, finalData, expVal);
        checkOutput({tag, "_target"}, targetSel, expTarget);
        checkOutput({tag, "_count"}, digitCount, 2'd0);
        @(negedge clock);
        checkOutput({tag, "_valid_end"}, finalValid, 1'b0);
        checkOutput({tag, "_hold"}, finalData, expVal);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data"}, finalData, 8'd0);
        checkOutput({tag, "_valid"}, finalValid, 1'b0);
        checkOutput({tag, "_target"}, targetSel, 2'd0);
        checkOutput({tag, "_count"}, digitCount, 2'd0);
        checkOutput({tag, "_digits"}, entryDigits, 12'h000);
        checkOutput({tag, "_error"}, entryError, 1'b0);
    endtask

    initial begin
        checkCount   = 0;
        failCount    = 0;
        reset        = 1'b1;
        keyPressed   = 1'b0;
        receivedData = 8'h00;
        #1;
        checkAllZero("reset");
        idleCycles(2);
        reset = 1'b0;
        idleCycles(1);

        // 4, break 4, 2, break 2, Enter -> 42
        applyStimulus(8'h25);
        checkOutput("d4_count", digitCount, 2'd1);
        applyStimulus(8'hF0);
        applyStimulus(8'h25);
        applyStimulus(8'h1E);
        applyStimulus(8'hF0);
        applyStimulus(8'h1E);
        checkOutput("d42_digits", entryDigits, 12'h042);
        checkOutput("d42_count", digitCount, 2'd2);
        commitAndCheck("c42", 1'b0, 8'd42, 2'd0);

        // 150 clamps to 100
        applyStimulus(8'h16);
        applyStimulus(8'h2E);
        applyStimulus(8'h45);
        checkOutput("d150_digits", entryDigits, 12'h150);
        commitAndCheck("c150", 1'b0, 8'd100, 2'd0);

        // Fourth digit rejected
        for (int i = 0; i < 3; i++) applyStimulus(8'h46);
        checkOutput("d99_noerr", entryError, 1'b0);
        applyStimulus(8'h46);
        checkOutput("d9999_err", entryError, 1'b1);
        checkOutput("d9999_count", digitCount, 2'd3);
        checkOutput("d9999_digits", entryDigits, 12'h999);
        @(negedge clock);
        checkOutput("d9999_err_end", entryError, 1'b0);
        commitAndCheck("c999", 1'b0, 8'd100, 2'd0);

        // 7,3,Backspace,5 -> 75
        applyStimulus(8'h3D);
        applyStimulus(8'h26);
        applyStimulus(8'h66);
        checkOutput("bksp_digits", entryDigits, 12'h007);
        checkOutput("bksp_count", digitCount, 2'd1);
        applyStimulus(8'h2E);
        checkOutput("d75_digits", entryDigits, 12'h075);
        commitAndCheck("c75", 1'b0, 8'd75, 2'd0);

        // Backspace of the only digit, then Escape mid-entry
        applyStimulus(8'h36);
        applyStimulus(8'h66);
        checkOutput("bksp_empty_count", digitCount, 2'd0);
        applyStimulus(8'h3E);
        applyStimulus(8'h76);
        checkOutput("esc_count", digitCount, 2'd0);
        checkOutput("esc_digits", entryDigits, 12'h000);
        checkOutput("esc_err", entryError, 1'b0);
        checkOutput("esc_valid", finalValid, 1'b0);
        idleCycles(2);
        checkOutput("esc_valid_late", finalValid, 1'b0);
        checkOutput("esc_data_held", finalData, 8'd75);

        // Enter with nothing entered
        applyStimulus(8'h5A);
        checkOutput("idle_enter_err", entryError, 1'b1);
        checkOutput("idle_enter_valid", finalValid, 1'b0);
        @(negedge clock);
        checkOutput("idle_enter_valid2", finalValid, 1'b0);

        // Tab cycling with 3 targets; Tab ignored mid-entry; keypad Enter
        applyStimulus(8'h0D);
        applyStimulus(8'h0D);
        checkOutput("tab2", targetSel, 2'd2);
        applyStimulus(8'h0D);
        checkOutput("tab_wrap", targetSel, 2'd0);
        applyStimulus(8'h0D);
        checkOutput("tab1", targetSel, 2'd1);
        applyStimulus(8'h3E);
        applyStimulus(8'h0D);
        checkOutput("tab_in_digits", targetSel, 2'd1);
        commitAndCheck("c8ext", 1'b1, 8'd8, 2'd1);
        applyStimulus(8'h0D);
        applyStimulus(8'h0D);
        checkOutput("tab_back0", targetSel, 2'd0);

        // Extended non-Enter and extended break Enter are discarded
        applyStimulus(8'h1E);
        applyStimulus(8'hE0);
        applyStimulus(8'h1E);
        checkOutput("ext_digit_count", digitCount, 2'd1);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h5A);
        idleCycles(2);
        checkOutput("ext_brk_valid", finalValid, 1'b0);
        checkOutput("ext_brk_count", digitCount, 2'd1);
        checkOutput("ext_brk_data", finalData, 8'd8);
        applyStimulus(8'h76);

        // Timeout after 16 idle cycles in mid-entry
        applyStimulus(8'h36);
        idleCycles(15);
        checkOutput("to_before_err", entryError, 1'b0);
        checkOutput("to_before_count", digitCount, 2'd1);
        idleCycles(1);
        checkOutput("to_err", entryError, 1'b1);
        checkOutput("to_count", digitCount, 2'd0);
        checkOutput("to_digits", entryDigits, 12'h000);
        @(negedge clock);
        checkOutput("to_err_end", entryError, 1'b0);

        // Any accepted strobe (even an ignored Tab) restarts the idle timer
        applyStimulus(8'h2E);
        idleCycles(10);
        applyStimulus(8'h0D);
        idleCycles(10);
        checkOutput("reload_count", digitCount, 2'd1);
        checkOutput("reload_err", entryError, 1'b0);
        applyStimulus(8'h76);

        // Asynchronous reset mid-entry
        applyStimulus(8'h0D);
        applyStimulus(8'h26);
        checkOutput("pre_reset_target", targetSel, 2'd1);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        idleCycles(2);
        reset = 1'b0;
        idleCycles(1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/keypad_entry_controller.md
Name: keypad_entry_controller

Overview:
Sequences numeric entry from the PS/2 byte stream into a committed 0..MAX_VALUE parameter value for the amp effect chain. It decodes make, break (F0) and extended (E0) prefixes. It collects up to 3 decimal digits with backspace and escape, commits on Enter, clamps the result, and tags it with a selected effect target. It sits between the PS/2 receiver and the effect parameter registers.

Parameters:
NUM_TARGETS, 4, number of effect parameters selectable via Tab (2..16).
MAX_VALUE, 100, clamp ceiling for committed value (≤255).
TIMEOUT_CYCLES, 250000000, idle cycles in mid-entry before the entry is abandoned (5 s at 50 MHz).

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
received_data  in  8  PS/2 scan byte
key_pressed  in  1  one-cycle strobe: received_data valid
final_data  out  8  last committed value, held
final_valid  out  1  one-cycle pulse on commit
target_sel  out  $clog2(NUM_TARGETS)  target of the pending/committed value
digit_count  out  2  digits currently entered (0..3)
entry_digits  out  12  BCD {d2,d1,d0}, d0 most recent, for HEX display
entry_error  out  1  one-cycle pulse on rejected action or timeout

Behaviour:
- Reset (async, high): all outputs 0; FSM to S_IDLE; prefix flags, digits and timer cleared.
- Only bytes with key_pressed=1 are processed; at most one byte per cycle.
- Prefixes: 0xF0 sets brk; 0xE0 sets ext. A non-prefix byte with brk set is discarded, and brk/ext are cleared. A non-prefix byte with ext set (no brk): only 0x5A (keypad Enter) acts, as Enter; others are discarded. Flags clear after any non-prefix byte.
- Digit codes (set 2): 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46. Enter=5A, Backspace=66, Escape=76, Tab=0D. All other codes are ignored.
- Each make code is one keystroke, so typematic repeats count.
- FSM states: S_IDLE (0 digits), S_DIGITS (1..3), S_COMMIT (1 cycle).
- S_IDLE:
  - Digit: shift into d0, count=1, go to S_DIGITS.
  - Tab: target_sel = (target_sel+1) mod NUM_TARGETS.
  - Enter: entry_error pulse.
  - Backspace/Escape: no effect.
- S_DIGITS:
  - Digit with count<3: shift left (d2←d1, d1←d0, d0←new), count+1.
  - Digit with count=3: ignored, entry_error pulse.
  - Backspace: shift right (d0←d1, d1←d2, d2←0), count−1; count 0 goes to S_IDLE.
  - Escape: clear digits, go to S_IDLE, no error.
  - Tab: ignored.
  - Enter: register value = d2*100 + d1*10 + d0 (10-bit), go to S_COMMIT.
- S_COMMIT:
  - final_data = min(value, MAX_VALUE); final_valid=1 this cycle; digits cleared; go to S_IDLE.
  - A byte arriving in S_COMMIT is processed as in S_IDLE against the cleared entry.
- Latency: Enter strobe at cycle t → final_data/final_valid visible at t+2.
- Timeout:
  - The 28-bit counter runs only in S_DIGITS. It reloads on every accepted strobe, including prefixes.
  - On reaching TIMEOUT_CYCLES−1: clear digits, go to S_IDLE, entry_error pulse.
  - Timeout and strobe in the same cycle: the strobe wins, and the counter reloads.
- target_sel changes only via Tab in S_IDLE/S_COMMIT and is stable while final_valid is high.
- final_data holds until the next commit or Reset.

Decomposition:
- Package keypad_pkg: scan code constants (SC_BREAK, SC_EXT, SC_ENTER, SC_BKSP, SC_ESC, SC_TAB, digit codes) and FSM state encodings.
- Sub-module scancode_to_digit: combinational map from 8-bit code to {is_digit, 4-bit BCD}.

Test Plan:
- Bytes 25,F0,25,1E,F0,1E,5A → final_data=42, final_valid single pulse 2 cycles after 5A, digit_count 0.
- Digits 1,5,0 then Enter → final_data=100 (clamped from 150).
- Digits 9,9,9,9 → entry_error pulse on 4th, digit_count=3, entry_digits=12'h999; Enter → 100.
- Digits 7,3, Backspace (66), 5, Enter → 75; Escape mid-entry → digit_count 0, no final_valid, no error.
- NUM_TARGETS=3: Tab×2 → target_sel=2, Tab → 0. Digit 8 then E0,5A → final_data=8, target_sel=0. E0,F0,5A → no commit.
- TIMEOUT_CYCLES=16: digit 6 then 16 idle cycles → entry_error pulse, digit_count 0. Reset asserted after digit 3 → all outputs 0 immediately.
